// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared widths, FSM encoding and byte-enable helper for the 2048x32 SRAM controller.
package ct_spsram_ctrl_pkg;
  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 32;
  localparam int BYTE_NUM   = 4;
  localparam int SRAM_DEPTH = 2048;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Active-low bit write enables: a cleared byte enable masks its 8 bits.
  function automatic logic [DATA_WIDTH-1:0] be_to_wen(input logic [BYTE_NUM-1:0] be);
    logic [DATA_WIDTH-1:0] wen;
    wen = {DATA_WIDTH{1'b1}};
    for (int i = 0; i < BYTE_NUM; i++) begin
      wen[8*i +: 8] = {8{~be[i]}};
    end
    return wen;
  endfunction
endpackage

// File: rtl/ct_f_spsram_2048x32_ctrl_if.sv
// Request/response channel between a requester (master) and the SRAM controller (slave).
interface ct_f_spsram_2048x32_ctrl_if;
  import ct_spsram_ctrl_pkg::*;

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BYTE_NUM-1:0]   req_be;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/ct_spsram_rsp_skid.sv
// Read response stage: bypasses SRAM Q in the cycle after a read, parks it in one skid entry on backpressure.
module ct_spsram_rsp_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  rd_fire_i,
  input  logic                  rsp_rdy_i,
  input  logic [DATA_WIDTH-1:0] sram_q_i,
  output logic                  rsp_vld_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  stall_o
);
  logic                  rd_pend_q, rd_pend_d;
  logic                  buf_vld_q, buf_vld_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;

  // rd_pend and buf_vld are never both set: a read is only accepted with the buffer empty.
  always_comb begin
    rd_pend_d  = rd_fire_i;
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    if (buf_vld_q) begin
      buf_vld_d = !rsp_rdy_i;
    end else if (rd_pend_q && !rsp_rdy_i) begin
      buf_vld_d  = 1'b1;
      buf_data_d = sram_q_i;
    end else begin
      buf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_pend_q  <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_pend_q  <= rd_pend_d;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign rsp_vld_o   = rd_pend_q || buf_vld_q;
  assign rsp_rdata_o = buf_vld_q ? buf_data_q : (rd_pend_q ? sram_q_i : {DATA_WIDTH{1'b0}});
  assign stall_o     = buf_vld_q || (rd_pend_q && !rsp_rdy_i);
endmodule

// File: rtl/ct_f_spsram_2048x32_ctrl.sv
// Request/response front end owning every pin of the 2048x32 single-port SRAM macro.
// Defining CT_SPSRAM_CTRL_INIT_EN adds a post-reset sweep writing INIT_VALUE to every entry.
module ct_f_spsram_2048x32_ctrl #(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  ct_f_spsram_2048x32_ctrl_if.slave bus,
  output logic                      init_done,
  output logic                      sram_cen,
  output logic                      sram_gwen,
  output logic [DATA_WIDTH-1:0]     sram_wen,
  output logic [ADDR_WIDTH-1:0]     sram_a,
  output logic [DATA_WIDTH-1:0]     sram_d,
  input  logic [DATA_WIDTH-1:0]     sram_q
);
  import ct_spsram_ctrl_pkg::*;

  ctrl_state_e           state_q;
  logic                  init_s;
  logic [ADDR_WIDTH-1:0] init_addr_s;
  logic                  req_rdy_s;
  logic                  rd_fire_s;
  logic                  stall_s;
  logic                  rsp_vld_s;
  logic [DATA_WIDTH-1:0] rsp_rdata_s;

`ifdef CT_SPSRAM_CTRL_INIT_EN
  ctrl_state_e           state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wrap_s;

  // The sweep counter's carry-out on the last entry is the INIT exit condition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_s  = 1'b0;
    if (state_q == INIT) begin
      {wrap_s, cnt_d} = {1'b0, cnt_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
      state_d         = wrap_s ? RUN : INIT;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= INIT;
      cnt_q   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_s      = cpurst_b && (state_q == INIT);
  assign init_addr_s = cnt_q;
`else
  assign state_q     = RUN;
  assign init_s      = 1'b0;
  assign init_addr_s = {ADDR_WIDTH{1'b0}};
`endif

  assign init_done = (state_q == RUN);
  // Gating with cpurst_b keeps the channel and SRAM strobes idle while reset is held.
  assign req_rdy_s = cpurst_b && (state_q == RUN) && !stall_s;
  assign rd_fire_s = bus.req_vld && req_rdy_s && !bus.req_wr;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = {DATA_WIDTH{1'b1}};
    sram_a    = bus.req_addr;
    sram_d    = bus.req_wdata;
    if (init_s) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = {DATA_WIDTH{1'b0}};
      sram_a    = init_addr_s;
      sram_d    = INIT_VALUE;
    end else if (cpurst_b) begin
      sram_cen  = !(bus.req_vld && req_rdy_s);
      sram_gwen = !bus.req_wr;
      sram_wen  = be_to_wen(bus.req_be);
    end else begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
    end
  end

  ct_spsram_rsp_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_skid (
    .clk         (forever_cpuclk),
    .rst_b       (cpurst_b),
    .rd_fire_i   (rd_fire_s),
    .rsp_rdy_i   (bus.rsp_rdy),
    .sram_q_i    (sram_q),
    .rsp_vld_o   (rsp_vld_s),
    .rsp_rdata_o (rsp_rdata_s),
    .stall_o     (stall_s)
  );

  assign bus.req_rdy   = req_rdy_s;
  assign bus.rsp_vld   = rsp_vld_s;
  assign bus.rsp_rdata = rsp_rdata_s;
endmodule

// File: tb/tb_ct_f_spsram_2048x32_ctrl.sv
// Directed bench for ct_f_spsram_2048x32_ctrl with a behavioural SRAM and a reference model checked every cycle.
module tb_ct_f_spsram_2048x32_ctrl;
  import ct_spsram_ctrl_pkg::*;

`ifdef CT_SPSRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam logic [31:0] INIT_VAL = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        sram_cen;
  logic        sram_gwen;
  logic [31:0] sram_wen;
  logic [10:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  int vectors     = 0;
  int miscompares = 0;

  ct_f_spsram_2048x32_ctrl_if bus_if ();

  ct_f_spsram_2048x32_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus_if),
    .init_done      (init_done),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk_w(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Pre-existing SRAM content for entries never written since time zero.
  function automatic logic [31:0] pat(input logic [10:0] a);
    return 32'hC0DE_0000 | {21'd0, a};
  endfunction

  function automatic logic [31:0] exp_wen(input logic [3:0] be);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = be[i] ? 8'h00 : 8'hFF;
    return w;
  endfunction

  // Behavioural SRAM macro: 1-cycle read latency, per-bit active-low write mask.
  logic [31:0] sram_mem [SRAM_DEPTH];
  bit          sram_wr  [SRAM_DEPTH];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        sram_mem[sram_a] <= ((sram_wr[sram_a] ? sram_mem[sram_a] : pat(sram_a)) & sram_wen) | (sram_d & ~sram_wen);
        sram_wr[sram_a]  <= 1'b1;
      end else begin
        sram_q <= sram_wr[sram_a] ? sram_mem[sram_a] : pat(sram_a);
      end
    end
  end

  // Reference model: array contents plus the single outstanding response slot.
  logic [31:0] ref_mem [SRAM_DEPTH];
  bit          ref_wr  [SRAM_DEPTH];
  bit          have_rsp;
  bit          rsp_fresh;
  logic [31:0] rsp_data;
  bit          exp_init_done;
  int          init_cnt;

  function automatic bit model_rdy();
    return exp_init_done && (!have_rsp || (rsp_fresh && bus_if.rsp_rdy));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit          acc;
    logic [31:0] cur;
    if (!rst_n) begin
      have_rsp      <= 1'b0;
      rsp_fresh     <= 1'b0;
      init_cnt      <= 0;
      exp_init_done <= INIT_EN ? 1'b0 : 1'b1;
    end else if (!exp_init_done) begin
      ref_mem[init_cnt[10:0]] <= INIT_VAL;
      ref_wr[init_cnt[10:0]]  <= 1'b1;
      init_cnt                <= init_cnt + 1;
      if (init_cnt == SRAM_DEPTH - 1) exp_init_done <= 1'b1;
    end else begin
      acc = bus_if.req_vld && model_rdy();
      cur = ref_wr[bus_if.req_addr] ? ref_mem[bus_if.req_addr] : pat(bus_if.req_addr);
      rsp_fresh <= 1'b0;
      if (have_rsp && bus_if.rsp_rdy) have_rsp <= 1'b0;
      if (acc && bus_if.req_wr) begin
        for (int i = 0; i < 4; i++) if (bus_if.req_be[i]) cur[8*i +: 8] = bus_if.req_wdata[8*i +: 8];
        ref_mem[bus_if.req_addr] <= cur;
        ref_wr[bus_if.req_addr]  <= 1'b1;
      end else if (acc) begin
        have_rsp  <= 1'b1;
        rsp_fresh <= 1'b1;
        rsp_data  <= cur;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_b("rst req_rdy", bus_if.req_rdy, 1'b0);
      chk_b("rst rsp_vld", bus_if.rsp_vld, 1'b0);
      chk_w("rst rsp_rdata", bus_if.rsp_rdata, 32'h0);
      chk_b("rst init_done", init_done, !INIT_EN);
      chk_b("rst cen", sram_cen, 1'b1);
      chk_b("rst gwen", sram_gwen, 1'b1);
      chk_w("rst wen", sram_wen, 32'hFFFF_FFFF);
    end else begin
      chk_b("init_done", init_done, exp_init_done);
      chk_b("req_rdy", bus_if.req_rdy, model_rdy());
      chk_b("rsp_vld", bus_if.rsp_vld, have_rsp);
      if (have_rsp) chk_w("rsp_rdata", bus_if.rsp_rdata, rsp_data);
      if (!exp_init_done) begin
        chk_b("sweep cen", sram_cen, 1'b0);
        chk_b("sweep gwen", sram_gwen, 1'b0);
        chk_w("sweep wen", sram_wen, 32'h0);
        chk_w("sweep a", {21'd0, sram_a}, {21'd0, init_cnt[10:0]});
        chk_w("sweep d", sram_d, INIT_VAL);
      end else begin
        chk_b("cen", sram_cen, !(bus_if.req_vld && model_rdy()));
        chk_b("gwen", sram_gwen, !bus_if.req_wr);
        chk_w("wen", sram_wen, exp_wen(bus_if.req_be));
        chk_w("a", {21'd0, sram_a}, {21'd0, bus_if.req_addr});
        chk_w("d", sram_d, bus_if.req_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [10:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus_if.req_vld   = 1'b1;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = data;
    bus_if.req_be    = be;
  endtask

  task automatic idle();
    bus_if.req_vld = 1'b0;
    bus_if.req_wr  = 1'b0;
  endtask

  // Hold one request until it is taken (bounded), then drop valid just after the accepting edge.
  task automatic issue(input logic wr, input logic [10:0] addr, input logic [31:0] data, input logic [3:0] be);
    int n;
    n = 0;
    set_req(wr, addr, data, be);
    @(negedge clk);
    while (!bus_if.req_rdy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk_b("issue accept", bus_if.req_rdy, 1'b1);
    tick();
    idle();
  endtask

  initial begin
    int n_ok;
    int n;
    rst_n            = 1'b0;
    bus_if.req_vld   = 1'b0;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = 11'd0;
    bus_if.req_wdata = 32'd0;
    bus_if.req_be    = 4'd0;
    bus_if.rsp_rdy   = 1'b1;
    repeat (2) @(negedge clk);
    #2;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    rst_n = 1'b1;
    #1;
    n_ok = 0;
    for (int i = 0; i < 2048; i++) begin
      if (!sram_cen && !sram_gwen && sram_wen == 32'h0 && sram_a == 11'(i) && sram_d == 32'h0 && !bus_if.req_rdy) n_ok++;
      tick();
    end
    chk_w("sweep writes", n_ok, 32'd2048);
    chk_b("init_done at 2049", init_done, 1'b1);
    issue(1'b0, 11'h7FF, 32'h0, 4'h0);
    @(negedge clk);
    chk_w("read 7FF after init", bus_if.rsp_rdata, 32'h0000_0000);
    tick();
`else
    set_req(1'b1, 11'd0, 32'hDEAD_BEEF, 4'hF);
    rst_n = 1'b1;
    #1;
    chk_b("no-init init_done", init_done, 1'b1);
    chk_b("first-cycle req_rdy", bus_if.req_rdy, 1'b1);
    chk_b("first-cycle cen", sram_cen, 1'b0);
    tick();
    set_req(1'b0, 11'd0, 32'h0, 4'h0);
    @(negedge clk);
    chk_b("second-cycle req_rdy", bus_if.req_rdy, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk_w("early DEADBEEF", bus_if.rsp_rdata, 32'hDEAD_BEEF);
    tick();
`endif
    // Byte enables
    issue(1'b1, 11'd5, 32'hAABB_CCDD, 4'hF);
    set_req(1'b1, 11'd5, 32'h1122_3344, 4'b0101);
    @(negedge clk);
    chk_w("partial wen", sram_wen, 32'hFF00_FF00);
    tick();
    idle();
    issue(1'b0, 11'd5, 32'h0, 4'h0);
    @(negedge clk);
    chk_w("merged bytes", bus_if.rsp_rdata, 32'hAA22_CC44);
    tick();
    issue(1'b1, 11'd5, 32'hFFFF_FFFF, 4'h0);
    issue(1'b0, 11'd5, 32'h0, 4'h0);
    @(negedge clk);
    chk_w("be=0 no change", bus_if.rsp_rdata, 32'hAA22_CC44);
    tick();
    // Read then write same address, then read back
    set_req(1'b0, 11'd5, 32'h0, 4'h0);
    tick();
    set_req(1'b1, 11'd5, 32'h5566_7788, 4'hF);
    @(negedge clk);
    chk_w("read before write", bus_if.rsp_rdata, 32'hAA22_CC44);
    tick();
    idle();
    issue(1'b0, 11'd5, 32'h0, 4'h0);
    @(negedge clk);
    chk_w("read after write", bus_if.rsp_rdata, 32'h5566_7788);
    tick();
    // Back-to-back reads
    issue(1'b1, 11'd1, 32'h1111_0001, 4'hF);
    issue(1'b1, 11'd2, 32'h2222_0002, 4'hF);
    issue(1'b1, 11'd3, 32'h3333_0003, 4'hF);
    set_req(1'b0, 11'd1, 32'h0, 4'h0);
    tick();
    set_req(1'b0, 11'd2, 32'h0, 4'h0);
    @(negedge clk);
    chk_b("b2b rdy 2", bus_if.req_rdy, 1'b1);
    chk_w("b2b rsp 1", bus_if.rsp_rdata, 32'h1111_0001);
    tick();
    set_req(1'b0, 11'd3, 32'h0, 4'h0);
    @(negedge clk);
    chk_b("b2b rdy 3", bus_if.req_rdy, 1'b1);
    chk_w("b2b rsp 2", bus_if.rsp_rdata, 32'h2222_0002);
    tick();
    idle();
    @(negedge clk);
    chk_w("b2b rsp 3", bus_if.rsp_rdata, 32'h3333_0003);
    tick();
    @(negedge clk);
    chk_b("b2b drained", bus_if.rsp_vld, 1'b0);
    // Backpressure into the skid entry
    issue(1'b1, 11'd9, 32'h1234_5678, 4'hF);
    bus_if.rsp_rdy = 1'b0;
    issue(1'b0, 11'd9, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_b("bp rsp_vld", bus_if.rsp_vld, 1'b1);
      chk_w("bp rdata", bus_if.rsp_rdata, 32'h1234_5678);
      chk_b("bp req_rdy", bus_if.req_rdy, 1'b0);
      tick();
    end
    bus_if.rsp_rdy = 1'b1;
    @(negedge clk);
    chk_w("bp drain data", bus_if.rsp_rdata, 32'h1234_5678);
    tick();
    @(negedge clk);
    chk_b("bp after drain vld", bus_if.rsp_vld, 1'b0);
    chk_b("bp after drain rdy", bus_if.req_rdy, 1'b1);
    tick();
    // Reset during the pending-read cycle
    issue(1'b0, 11'd9, 32'h0, 4'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_b("mid-read rst rsp_vld", bus_if.rsp_vld, 1'b0);
    chk_b("mid-read rst req_rdy", bus_if.req_rdy, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 3000) begin
      tick();
      n++;
    end
    chk_w("re-sweep length", n, INIT_EN ? 32'd2048 : 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_b("no stale rsp", bus_if.rsp_vld, 1'b0);
    end
    issue(1'b1, 11'd0, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 11'd0, 32'h0, 4'h0);
    @(negedge clk);
    chk_w("DEADBEEF readback", bus_if.rsp_rdata, 32'hDEAD_BEEF);
    tick();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
